// File: rtl/serial_mac_pkg.sv
// Shared types and helpers for the bit-serial dot-product MAC.
package serial_mac_pkg;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } mac_state_e;

  // Accumulator width: full lane product, room for summing all lanes, plus headroom.
  function automatic int acc_width(input int width, input int lanes, input int guard);
    return 2 * width + $clog2(lanes) + guard;
  endfunction

endpackage

// File: rtl/serial_dot_mac_if.sv
// Operand-in / result-out handshake bundle for serial_dot_mac.
interface serial_dot_mac_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 16,
  parameter int GUARD = 8
);
  import serial_mac_pkg::*;

  localparam int ACC_W = acc_width(WIDTH, LANES, GUARD);

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   a;
  logic [LANES*WIDTH-1:0]   b;
  logic                     signed_mode;
  logic                     accumulate;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out;

  // Producer / consumer side (drives operands, takes results).
  modport master (
    output in_valid, a, b, signed_mode, accumulate, out_ready,
    input  in_ready, out_valid, out
  );

  // MAC side.
  modport slave (
    input  in_valid, a, b, signed_mode, accumulate, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/serial_mac_lane.sv
// One shift-and-add multiplier lane; WIDTH step cycles give an exact 2*WIDTH product.
module serial_mac_lane #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 last,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] prod_r;
  logic               sgn_r;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] prod_nxt_s;

  // Widen the multiplicand to the product width according to the operand mode.
  always_comb begin
    ext_a_s = {{WIDTH{1'b0}}, op_a};
    if (signed_mode) begin
      ext_a_s = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    end else begin
      ext_a_s = {{WIDTH{1'b0}}, op_a};
    end
  end

  // Conditional add of the shifted multiplicand; the signed MSB weight is negative, so subtract.
  always_comb begin
    prod_nxt_s = prod_r;
    if (mplier_r[0]) begin
      if (last && sgn_r) begin
        prod_nxt_s = prod_r - mcand_r;
      end else begin
        prod_nxt_s = prod_r + mcand_r;
      end
    end else begin
      prod_nxt_s = prod_r;
    end
  end

  // Lane registers: load operands on acceptance, shift and accumulate on each step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      sgn_r    <= 1'b0;
    end else if (load) begin
      mcand_r  <= ext_a_s;
      mplier_r <= op_b;
      prod_r   <= {(2*WIDTH){1'b0}};
      sgn_r    <= signed_mode;
    end else if (step) begin
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      prod_r   <= prod_nxt_s;
    end
  end

  assign product = prod_r;

endmodule

// File: rtl/serial_dot_mac.sv
// Bit-serial dot-product MAC: LANES serial multipliers, one-cycle reduction, running accumulator.
module serial_dot_mac
  import serial_mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 16,
  parameter int GUARD = 8
) (
  input logic            clk,
  input logic            reset_n,
  serial_dot_mac_if.slave bus
);

  localparam int ACC_W = acc_width(WIDTH, LANES, GUARD);
  localparam int CNT_W = $clog2(WIDTH);

  mac_state_e         state_r;
  mac_state_e         state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic               signed_r;
  logic               accumulate_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_base_s;
  logic [ACC_W-1:0]   acc_nxt_s;
  logic [2*WIDTH-1:0] prod_s [LANES];
  logic [ACC_W-1:0]   psum_s [LANES+1];

  assign last_s = (cnt_r == {CNT_W{1'b0}});

  // Next-state and per-cycle strobes for the shared sequencer.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nxt_s = REDUCE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      REDUCE: state_nxt_s = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == HOLD);
    end
  end

  // Step counter and per-op mode flags captured at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      signed_r     <= 1'b0;
      accumulate_r <= 1'b0;
    end else if (load_s) begin
      cnt_r        <= CNT_W'(WIDTH - 1);
      signed_r     <= bus.signed_mode;
      accumulate_r <= bus.accumulate;
    end else if (step_s && !last_s) begin
      cnt_r        <= cnt_r - CNT_W'(1);
    end
  end

  assign psum_s[0] = {ACC_W{1'b0}};

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [ACC_W-1:0] ext_s;

    serial_mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (load_s),
      .step        (step_s),
      .last        (last_s),
      .signed_mode (bus.signed_mode),
      .op_a        (bus.a[j*WIDTH +: WIDTH]),
      .op_b        (bus.b[j*WIDTH +: WIDTH]),
      .product     (prod_s[j])
    );

    // Extend this lane's product to accumulator width per the captured mode.
    always_comb begin
      ext_s = ACC_W'(prod_s[j]);
      if (signed_r) begin
        ext_s = ACC_W'($signed(prod_s[j]));
      end else begin
        ext_s = ACC_W'(prod_s[j]);
      end
    end

    assign psum_s[j+1] = psum_s[j] + ext_s;
  end

  // Select whether the lane sum starts fresh or adds onto the running value.
  always_comb begin
    acc_base_s = {ACC_W{1'b0}};
    if (accumulate_r) begin
      acc_base_s = acc_r;
    end else begin
      acc_base_s = {ACC_W{1'b0}};
    end
    acc_nxt_s = acc_base_s + psum_s[LANES];
  end

  // Accumulator updates only in REDUCE, otherwise holds its value (wraps modulo 2^ACC_W).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (state_r == REDUCE) begin
      acc_r <= acc_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = acc_r;

endmodule
